mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the shared 128-word instruction/data memory.
//  Requester 0 (fetch) and requester 1 (load) post addresses. The arbiter drives the single
//  combinational memory read port, captures the word, and returns it to the winner.
//  Sits between the CPU front end and the memory block. Issues one access every 2 cycles.
// PARAMETERS
//  ADDR_W     32   width of request/memory address
//  DATA_W     32   width of memory data word
//  MEM_DEPTH  128  number of valid memory words (0..MEM_DEPTH-1)
// PORTS
//  clk        in   1       single clock; all state changes on rising edge
//  rst        in   1       asynchronous, active-high reset
//  req        in   2       req[i]=1: requester i wants a read; hold until gnt[i]
//  addr0      in   ADDR_W  requester 0 word address; held stable while req[0]
//  addr1      in   ADDR_W  requester 1 word address; held stable while req[1]
//  gnt        out  2       one-hot, 1-cycle pulse: request accepted, address sampled
//  rvalid     out  2       one-hot, 1-cycle pulse: rdata valid for requester i
//  rdata      out  DATA_W  read data; holds last value between accesses
//  err        out  1       out-of-range pulse, coincident with rvalid (MEM_ARB_BOUNDS_EN only)
//  mem_addr   out  ADDR_W  address to memory read port
//  mem_data   in   DATA_W  memory read data, combinational from mem_addr
// BEHAVIOUR
//  Reset (async): state=IDLE; gnt=0, rvalid=0, err=0, rdata=0, mem_addr=0; rr_last=1.
//   With rr_last=1, requester 0 wins the first tie.
//  FSM states: IDLE, BUSY.
//  IDLE, req!=0 at edge k:
//   - winner = only requester if single; if both, the one != rr_last
//   - latch winner's address into mem_addr; gnt[winner]<=1; rr_last<=winner; ->BUSY
//  IDLE, req==0: outputs hold, except gnt/rvalid/err are 0.
//  BUSY at edge k+1: rdata<=mem_data; rvalid[winner]<=1; gnt<=0; ->IDLE
//  Latency: req sampled at edge k -> gnt high in cycle k..k+1 -> rvalid/rdata in k+1..k+2.
//  Next accept is possible at edge k+2. Max one grant per 2 cycles.
//  mem_addr is stable through BUSY. It is not changed in IDLE until the next accept.
//  req/addr changes are ignored in BUSY. Dropping req after gnt does not cancel the access.
//  gnt and rvalid are never both high for different requesters in the same cycle.
//  Each is one-hot or zero.
//  Both requesters held continuously: grants alternate 0,1,0,1 with no starvation.
//  rst asserted mid-access: the access is abandoned and no rvalid is issued.
//   All outputs immediately take reset values; rr_last=1.
// CONFIGURATION
//  MEM_ARB_BOUNDS_EN defined:
//   - on accept, addr>=MEM_DEPTH is flagged
//   - mem_addr<=0, and in BUSY rdata<=0 with err=1 alongside rvalid
//   - the arbitration/rr update is unchanged
//  MEM_ARB_BOUNDS_EN undefined: address is passed to the memory unmodified; err tied to 0.
// STRUCTURE
//  Package mem_pkg:
//   - ADDR_W/DATA_W/MEM_DEPTH localparams
//   - typedef enum {IDLE,BUSY} arb_state_t
//   - requester index constants REQ_FETCH=0, REQ_LOAD=1
//  Sub-module rr_pick2: combinational (req[1:0], rr_last) -> one-hot winner.
//   Kept separate for unit test.
//  Top: FSM, address/winner registers, rdata/valid registers, optional bounds compare.
// TESTING (memory preloaded with MEM[n]=0xA00000nn pattern: MEM[0]=0xA00000AA, MEM[1]=0xA0000011...)
//  1. Reset, req=01, addr0=3
//     -> gnt=01 next cycle; rvalid=01 following cycle with rdata=0xA0000033.
//  2. req=11, addr0=1, addr1=2, held for 8 cycles
//     -> gnt order 0,1,0,1; rdata alternates 0xA0000011/0xA0000022.
//  3. req=10 addr1=9, then req dropped right after gnt
//     -> rvalid=10 still fires, rdata=0xA0000099.
//  4. rst pulsed in the BUSY cycle of an addr0=5 access
//     -> no rvalid; all outputs 0; next tie (req=11) grants requester 0.
//  5. MEM_ARB_BOUNDS_EN, addr0=200
//     -> rvalid=01, err=1, rdata=0, mem_addr=0. Without the macro, err stays 0.
//  6. Idle with req=00 for 10 cycles -> gnt, rvalid, err stay 0; rdata holds its last value.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared constants and types for the two-requester memory arbiter.
//   ADDR_W / DATA_W  : request/memory address and data word widths
//   MEM_DEPTH        : number of valid memory words (0..MEM_DEPTH-1)
//   arb_state_t      : arbiter FSM states
//   REQ_FETCH/LOAD   : bit index of each requester in req/gnt/rvalid
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 128;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LOAD  = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the requester handshake and the memory read port of the arbiter.
//   req[1:0]      requester -> arbiter  read request, held until gnt
//   addr0/addr1   requester -> arbiter  word address per requester
//   gnt[1:0]      arbiter -> requester  one-hot accept pulse
//   rvalid[1:0]   arbiter -> requester  one-hot read-data-valid pulse
//   rdata         arbiter -> requester  last read word
//   err           arbiter -> requester  out-of-range flag with rvalid
//   mem_addr      arbiter -> memory     read address
//   mem_data      memory  -> arbiter    combinational read data
// Modports: slave = arbiter side, master = requester/memory side.
// ---------------------------------------------------------------------------
import mem_pkg::*;

interface mem_arbiter_if;

    logic [1:0]        req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  req, addr0, addr1, mem_data,
        output gnt, rvalid, rdata, err, mem_addr
    );

    modport master (
        output req, addr0, addr1, mem_data,
        input  gnt, rvalid, rdata, err, mem_addr
    );

endinterface

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   i_req[1:0]  : pending requests
//   i_rr_last   : index of the requester that won most recently
//   o_win[1:0]  : one-hot winner (zero when nothing is requested)
// A lone requester always wins; on a tie the requester that did not win
// last time is chosen, so a continuously held pair alternates.
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_rr_last,
    output logic [1:0] o_win
);

    // Tie-break favours the requester other than the previous winner.
    always_comb begin
        o_win = 2'b00;
        case (i_req)
            2'b01:   o_win = 2'b01;
            2'b10:   o_win = 2'b10;
            2'b11:   o_win = i_rr_last ? 2'b01 : 2'b10;
            default: o_win = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter placing a fetch requester (0) and a load requester (1)
// in front of a single combinational memory read port. One access is issued
// at most every two cycles: accept (IDLE) then capture (BUSY).
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   arb_bus   : mem_arbiter_if.slave (req/addr in, gnt/rvalid/rdata/err out,
//               mem_addr out, mem_data in)
// Optional feature macro MEM_ARB_BOUNDS_EN: addresses >= MEM_DEPTH are
// flagged on accept, the memory is driven with address 0, and the reply
// carries rdata=0 with err=1. Without the macro addresses pass through
// unmodified and err is tied low.
// ---------------------------------------------------------------------------
import mem_pkg::*;

module mem_arbiter (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   arb_bus
);

    arb_state_t        r_state;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic [1:0]        r_win;
    logic              r_rrLast;
    logic              r_oob;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_memAddr;

    logic [1:0]        w_win;
    logic [ADDR_W-1:0] w_addrSel;
    logic              w_oob;

    rr_pick2 u_pick (
        .i_req     (arb_bus.req),
        .i_rr_last (r_rrLast),
        .o_win     (w_win)
    );

    assign w_addrSel = w_win[REQ_LOAD] ? arb_bus.addr1 : arb_bus.addr0;

`ifdef MEM_ARB_BOUNDS_EN
    assign w_oob = (w_addrSel >= ADDR_W'(MEM_DEPTH));
`else
    assign w_oob = 1'b0;
`endif

    // Two-state access engine. IDLE accepts a request and latches the
    // address; BUSY captures the memory word one cycle later. Requests seen
    // while BUSY are ignored, and mem_addr only moves on a new accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= 2'b00;
            r_rvalid  <= 2'b00;
            r_win     <= 2'b00;
            r_rrLast  <= 1'b1;
            r_oob     <= 1'b0;
            r_rdata   <= '0;
            r_memAddr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rvalid <= 2'b00;
                    if (|arb_bus.req) begin
                        r_gnt     <= w_win;
                        r_win     <= w_win;
                        r_rrLast  <= w_win[REQ_LOAD];
                        r_oob     <= w_oob;
                        r_memAddr <= w_oob ? '0 : w_addrSel;
                        r_state   <= BUSY;
                    end else begin
                        r_gnt <= 2'b00;
                    end
                end
                BUSY: begin
                    r_gnt    <= 2'b00;
                    r_rvalid <= r_win;
                    r_rdata  <= r_oob ? '0 : arb_bus.mem_data;
                    r_state  <= IDLE;
                end
                default: begin
                    r_gnt    <= 2'b00;
                    r_rvalid <= 2'b00;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_BOUNDS_EN
    logic r_err;

    // Error pulse rides alongside rvalid for an out-of-range access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == BUSY) ? r_oob : 1'b0;
        end
    end

    assign arb_bus.err = r_err;
`else
    assign arb_bus.err = 1'b0;
`endif

    assign arb_bus.gnt      = r_gnt;
    assign arb_bus.rvalid   = r_rvalid;
    assign arb_bus.rdata    = r_rdata;
    assign arb_bus.mem_addr = r_memAddr;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a transaction-level reference model.
// The memory holds MEM[n] = 0xA00000dd where d = n mod 10 (0 shown as A).
// Out-of-range reads of the memory model return 0xBAD0_0000 | addr[15:0].
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_pkg::*;

`ifdef MEM_ARB_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    int testsRun  = 0;
    int failCount = 0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .arb_bus (bus)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the arbiter's read port
    function automatic logic [31:0] memRead(input logic [31:0] a);
        logic [3:0] d;
        if (a < 32'd128) begin
            d = (a % 32'd10 == 32'd0) ? 4'hA : 4'(a % 32'd10);
            return 32'hA000_0000 | {24'h0, d, d};
        end
        return 32'hBAD0_0000 | {16'h0, a[15:0]};
    endfunction

    assign bus.mem_data = memRead(bus.mem_addr);

    // Reference model: a request seen at an edge where the port is free is
    // granted for the next cycle and answered one cycle after that; the port
    // is free again two edges after an accept.
    int          mCyc = 0;
    int          mFreeAt;
    int          mLast;
    logic [1:0]  mGnt, mRvalid;
    logic        mErr;
    logic [31:0] mRdata, mMemAddr;
    bit          mPendValid;
    int          mPendCyc;
    logic [1:0]  mPendWho;
    logic [31:0] mPendData;
    logic        mPendErr;

    always @(posedge clk or posedge rst) begin : refModel
        int          wIdx;
        logic [31:0] a;
        bit          oob;
        if (rst) begin
            mGnt       <= 2'b00;
            mRvalid    <= 2'b00;
            mErr       <= 1'b0;
            mRdata     <= 32'h0;
            mMemAddr   <= 32'h0;
            mLast      <= 1;
            mFreeAt    <= 0;
            mPendValid <= 1'b0;
        end else begin
            mCyc    <= mCyc + 1;
            mGnt    <= 2'b00;
            mRvalid <= 2'b00;
            mErr    <= 1'b0;
            if (mPendValid && mPendCyc == mCyc) begin
                mRvalid    <= mPendWho;
                mRdata     <= mPendData;
                mErr       <= mPendErr;
                mPendValid <= 1'b0;
            end
            if (mCyc >= mFreeAt && bus.req != 2'b00) begin
                if (bus.req == 2'b11) wIdx = 1 - mLast;
                else                  wIdx = bus.req[1] ? 1 : 0;
                a   = (wIdx == 1) ? bus.addr1 : bus.addr0;
                oob = BOUNDS_EN && (a >= 32'd128);
                mGnt       <= 2'(1 << wIdx);
                mLast      <= wIdx;
                mFreeAt    <= mCyc + 2;
                mMemAddr   <= oob ? 32'h0 : a;
                mPendValid <= 1'b1;
                mPendCyc   <= mCyc + 1;
                mPendWho   <= 2'(1 << wIdx);
                mPendData  <= oob ? 32'h0 : memRead(a);
                mPendErr   <= oob;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Every cycle: DUT outputs against the reference model
    always @(negedge clk) begin
        checkOutput("model gnt",      {30'h0, bus.gnt},    {30'h0, mGnt});
        checkOutput("model rvalid",   {30'h0, bus.rvalid}, {30'h0, mRvalid});
        checkOutput("model err",      {31'h0, bus.err},    {31'h0, mErr});
        checkOutput("model rdata",    bus.rdata,           mRdata);
        checkOutput("model mem_addr", bus.mem_addr,        mMemAddr);
    end

    task automatic applyStimulus(input logic [1:0] r, input logic [31:0] a0,
                                 input logic [31:0] a1);
        bus.req   = r;
        bus.addr0 = a0;
        bus.addr1 = a1;
    endtask

    // Request, drop the request as soon as the grant is visible
    task automatic issueAndDrop(input logic [1:0] r, input logic [31:0] a0,
                                input logic [31:0] a1);
        applyStimulus(r, a0, a1);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, a0, a1);
    endtask

    logic [1:0]  gSeq [8];
    logic [31:0] dSeq [8];
    int          gCount, dCount;
    logic [31:0] expErr, expData, expAddr;

    initial begin
        rst = 1'b1;
        applyStimulus(2'b00, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset gnt",      {30'h0, bus.gnt},    32'h0);
        checkOutput("reset rdata",    bus.rdata,           32'h0);
        checkOutput("reset mem_addr", bus.mem_addr,        32'h0);

        // 1: single fetch request
        issueAndDrop(2'b01, 32'd3, 32'd0);
        @(negedge clk);
        checkOutput("t1 gnt", {30'h0, bus.gnt}, 32'h1);
        @(negedge clk);
        checkOutput("t1 rvalid", {30'h0, bus.rvalid}, 32'h1);
        checkOutput("t1 rdata",  bus.rdata, 32'hA000_0033);

        // 2: both held for 8 cycles after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b11, 32'd1, 32'd2);
        gCount = 0;
        dCount = 0;
        for (int i = 0; i < 8; i++) begin
            gSeq[i] = 2'b00;
            dSeq[i] = 32'h0;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00 && gCount < 8) begin
                gSeq[gCount] = bus.gnt;
                gCount++;
            end
            if (bus.rvalid != 2'b00 && dCount < 8) begin
                dSeq[dCount] = bus.rdata;
                dCount++;
            end
        end
        applyStimulus(2'b00, 32'd1, 32'd2);
        checkOutput("t2 grant count", 32'(gCount), 32'd4);
        checkOutput("t2 reply count", 32'(dCount), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2 gnt[%0d]", i), {30'h0, gSeq[i]},
                        (i % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput($sformatf("t2 rdata[%0d]", i), dSeq[i],
                        (i % 2 == 0) ? 32'hA000_0011 : 32'hA000_0022);
        end

        // 3: load request dropped right after its grant
        issueAndDrop(2'b10, 32'd1, 32'd9);
        @(negedge clk);
        checkOutput("t3 gnt", {30'h0, bus.gnt}, 32'h2);
        @(negedge clk);
        checkOutput("t3 rvalid", {30'h0, bus.rvalid}, 32'h2);
        checkOutput("t3 rdata",  bus.rdata, 32'hA000_0099);

        // 4: reset during the capture cycle
        issueAndDrop(2'b01, 32'd5, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("t4 rst gnt",      {30'h0, bus.gnt}, 32'h0);
        checkOutput("t4 rst rdata",    bus.rdata,        32'h0);
        checkOutput("t4 rst mem_addr", bus.mem_addr,     32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4 no rvalid", {30'h0, bus.rvalid}, 32'h0);
        rst = 1'b0;
        issueAndDrop(2'b11, 32'd1, 32'd2);
        @(negedge clk);
        checkOutput("t4 tie gnt", {30'h0, bus.gnt}, 32'h1);
        @(negedge clk);
        checkOutput("t4 rdata", bus.rdata, 32'hA000_0011);

        // 5: out-of-range fetch address
        expErr  = BOUNDS_EN ? 32'h1 : 32'h0;
        expData = BOUNDS_EN ? 32'h0 : 32'hBAD0_00C8;
        expAddr = BOUNDS_EN ? 32'h0 : 32'd200;
        issueAndDrop(2'b01, 32'd200, 32'd0);
        @(negedge clk);
        checkOutput("t5 mem_addr", bus.mem_addr, expAddr);
        @(negedge clk);
        checkOutput("t5 rvalid", {30'h0, bus.rvalid}, 32'h1);
        checkOutput("t5 err",    {31'h0, bus.err},    expErr);
        checkOutput("t5 rdata",  bus.rdata,           expData);

        // 5b: last valid word is never flagged
        issueAndDrop(2'b10, 32'd0, 32'd127);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5b err",   {31'h0, bus.err}, 32'h0);
        checkOutput("t5b rdata", bus.rdata,        32'hA000_0077);

        // 6: idle, outputs quiet and rdata held
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t6 gnt",    {30'h0, bus.gnt},    32'h0);
            checkOutput("t6 rvalid", {30'h0, bus.rvalid}, 32'h0);
            checkOutput("t6 rdata",  bus.rdata,           32'hA000_0077);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
